mandelbrot_pixel_streamer: RTL
==============================

// Module: mandelbrot_pixel_streamer
// PURPOSE
// - Read-side consumer of the Mandelbrot frame-buffer scan-out (RGB555 pixel + X/Y coordinate per beat).
// - Checks raster order and buffers pixels in a small FIFO.
// - Emits a video stream: valid/ready, RGB888 data, start-of-frame (tuser) and end-of-line (tlast) markers.
// - Sits between the frame-buffer read port and the display/VGA output path.
// PARAMETERS
// - FIFO_DEPTH  16  entries in internal FIFO; power of two, >=2
// - RGB_W       15  input pixel width, fixed layout {R[14:10],G[9:5],B[4:0]}
// - COORD_W     10  width of X/Y coordinates and of x_size/y_size
// PORTS
// - clk         in   1        single clock
// - rst         in   1        synchronous, active-low reset
// - in_valid    in   1        input pixel beat present
// - in_ready    out  1        block can accept a beat; equals !fifo_full
// - in_rgb      in   15       RGB555 pixel
// - in_x        in   10       pixel column
// - in_y        in   10       pixel row
// - x_size      in   10       frame width; latched at frame start
// - y_size      in   10       frame height; latched at frame start
// - out_tdata   out  24       RGB888 {R8,G8,B8}
// - out_tvalid  out  1        output beat valid
// - out_tready  in   1        downstream accepts beat
// - out_tuser   out  1        first pixel of frame (0,0)
// - out_tlast   out  1        last pixel of a line (x == x_size-1)
// - frame_done  out  1        1-cycle pulse when the last pixel of a frame handshakes on output
// - err_seq     out  1        sticky raster-order error; cleared only by reset
// BEHAVIOUR
// - Reset (rst==0 at posedge): FIFO emptied, FSM->SYNC.
//   - Outputs: out_tvalid=0, out_tdata=0, out_tuser=0, out_tlast=0, frame_done=0, err_seq=0, in_ready=0.
//   - in_ready rises the cycle after rst goes high.
//   - Reset mid-frame discards all buffered pixels; no partial beat is completed.
// - Input accept = in_valid && in_ready. in_ready = !full. A push is refused when full, even if a pop occurs in the same cycle.
// - FSM states:
//   - SYNC: accepted beats are dropped unless (in_x,in_y)==(0,0).
//     - On (0,0): latch x_size/y_size, push with tuser=1, set expect=(1,0) (or next row if x_size==1), go STREAM.
//     - If the latched x_size==0 or y_size==0, the beat is dropped and the FSM stays in SYNC.
//   - STREAM: each accepted beat is compared with the expected (ex,ey).
//     - Match: push; tlast=(ex==xs-1). ex wraps to 0 at xs-1 and ey increments.
//     - At (xs-1,ys-1): push with tlast=1, set a last-of-frame flag in the entry, go SYNC.
//     - Mismatch: drop beat, set err_seq, go SYNC. A mismatching beat at (0,0) is not reused as SOF.
// - FIFO entry: {rgb555, tuser, tlast, eof} = 18 bits.
// - Output register: loads from FIFO when !out_tvalid || out_tready.
//   - Data/flags stay stable while out_tvalid && !out_tready.
// - Latency: a push into an empty FIFO appears on out_tvalid 2 cycles later (FIFO write, then output register).
//   - Sustained throughput is 1 beat/cycle when out_tready=1.
// - Colour expansion: R8={R5,R5[4:2]}, G8={G5,G5[4:2]}, B8={B5,B5[4:2]}.
//   - Examples: 0x7FFF->0xFFFFFF, 0x0000->0x000000.
// - frame_done: 1-cycle pulse on the out_tvalid&&out_tready cycle of an entry with eof=1.
// - Simultaneous push and pop with the FIFO not full: both occur; count unchanged.
// STRUCTURE
// - mandelbrot_pkg: RGB_W, COORD_W, rgb555_t struct, fifo_entry_t struct, stream_state_e enum {SYNC,STREAM}.
// - rgb555_to_888 function in mandelbrot_pkg.
// - Sub-module sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/rdata; same clk/rst).
// - Top holds the FSM, expected-coordinate counters and the output register.
// TESTING
// - Reset with in_valid=1 -> all outputs 0, in_ready=0; in_ready=1 exactly one cycle after rst release.
// - 4x2 frame, x_size=4, y_size=2, out_tready=1 -> 8 beats; tuser only on beat 0; tlast on beats 3 and 7; frame_done with beat 7.
// - in_rgb=0x7C00 at (0,0) -> out_tdata=0xFF0000; in_rgb=0x0421 -> 0x080808.
// - out_tready=0 while feeding 20 pixels (FIFO_DEPTH=16) -> in_ready low after 16 pushes (17 with the output register full); no loss or reorder after release.
// - Stream (0,0),(1,0),(3,0) with x_size=4 -> err_seq=1, (3,0) dropped, later beats dropped until the next (0,0); new frame streams normally.
// - Assert rst mid-frame with 5 pixels buffered -> out_tvalid=0 next cycle; the following frame's first beat carries tuser=1.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared types and helpers for the Mandelbrot frame-buffer scan-out streamer.
// Holds the pixel/FIFO entry layouts, the raster FSM states and the colour expander.
package mandelbrot_pkg;

   localparam int RGB_W   = 15;
   localparam int COORD_W = 10;

   typedef struct packed {
      logic [4:0] r;
      logic [4:0] g;
      logic [4:0] b;
   } rgb555_t;

   typedef struct packed {
      rgb555_t rgb;
      logic    tuser;
      logic    tlast;
      logic    eof;
   } fifo_entry_t;

   localparam int ENTRY_W = $bits(fifo_entry_t);

   typedef enum logic {
      SYNC   = 1'b0,
      STREAM = 1'b1
   } stream_state_e;

   // Replicating the top bits into the low bits maps full-scale 5-bit to full-scale 8-bit.
   function automatic logic [23:0] rgb555_to_888(input rgb555_t p);
      return {p.r, p.r[4:2], p.g, p.g[4:2], p.b, p.b[4:2]};
   endfunction

endpackage

// File: rtl/mandelbrot_pixel_streamer_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; push is refused when full and
// pop is ignored when empty, so callers may assert them unconditionally.
module sync_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];

   // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/mandelbrot_pixel_streamer.sv
// Frame-buffer scan-out consumer: checks raster order, buffers pixels and emits
// an RGB888 valid/ready stream with start-of-frame and end-of-line markers.
module mandelbrot_pixel_streamer
   import mandelbrot_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [RGB_W-1:0]   in_rgb,
   input  logic [COORD_W-1:0] in_x,
   input  logic [COORD_W-1:0] in_y,
   input  logic [COORD_W-1:0] x_size,
   input  logic [COORD_W-1:0] y_size,
   output logic [23:0]        out_tdata,
   output logic               out_tvalid,
   input  logic               out_tready,
   output logic               out_tuser,
   output logic               out_tlast,
   output logic               frame_done,
   output logic               err_seq
);

   localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

   stream_state_e      state_q, state_d;
   logic [COORD_W-1:0] ex_q, ex_d;
   logic [COORD_W-1:0] ey_q, ey_d;
   logic [COORD_W-1:0] xs_q, xs_d;
   logic [COORD_W-1:0] ys_q, ys_d;
   logic               err_q, err_d;
   logic               run_q;

   logic               out_tvalid_q;
   logic [23:0]        out_tdata_q;
   logic               out_tuser_q;
   logic               out_tlast_q;
   logic               out_eof_q;

   logic               accept;
   logic               at_origin;
   logic               last_col;
   logic               last_row;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic               out_load;
   fifo_entry_t        wr_entry;
   fifo_entry_t        rd_entry;

   assign in_ready  = run_q && !fifo_full;
   assign accept    = in_valid && in_ready;
   assign at_origin = (in_x == '0) && (in_y == '0);
   assign last_col  = (ex_q == xs_q - ONE);
   assign last_row  = (ey_q == ys_q - ONE);

   // Raster-order check: decide whether the accepted beat is pushed and where the scan goes next.
   always_comb begin
      state_d        = state_q;
      ex_d           = ex_q;
      ey_d           = ey_q;
      xs_d           = xs_q;
      ys_d           = ys_q;
      err_d          = err_q;
      fifo_push      = 1'b0;
      wr_entry.rgb   = rgb555_t'(in_rgb);
      wr_entry.tuser = 1'b0;
      wr_entry.tlast = 1'b0;
      wr_entry.eof   = 1'b0;
      case (state_q)
         SYNC: begin
            if (accept && at_origin && (x_size != '0) && (y_size != '0)) begin
               xs_d           = x_size;
               ys_d           = y_size;
               fifo_push      = 1'b1;
               wr_entry.tuser = 1'b1;
               wr_entry.tlast = (x_size == ONE);
               if ((x_size == ONE) && (y_size == ONE)) begin
                  wr_entry.eof = 1'b1;
               end else if (x_size == ONE) begin
                  ex_d    = '0;
                  ey_d    = ONE;
                  state_d = STREAM;
               end else begin
                  ex_d    = ONE;
                  ey_d    = '0;
                  state_d = STREAM;
               end
            end else begin
               state_d = SYNC;
            end
         end
         STREAM: begin
            if (!accept) begin
               state_d = STREAM;
            end else if ((in_x == ex_q) && (in_y == ey_q)) begin
               fifo_push      = 1'b1;
               wr_entry.tlast = last_col;
               if (last_col && last_row) begin
                  wr_entry.eof = 1'b1;
                  state_d      = SYNC;
               end else if (last_col) begin
                  ex_d = '0;
                  ey_d = ey_q + ONE;
               end else begin
                  ex_d = ex_q + ONE;
               end
            end else begin
               // Even a stray (0,0) here is dropped; resync waits for the next origin beat.
               err_d   = 1'b1;
               state_d = SYNC;
            end
         end
         default: begin
            state_d = SYNC;
         end
      endcase
   end

   // FSM, coordinate counters, latched frame size, sticky error and post-reset ready enable.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= SYNC;
         ex_q    <= '0;
         ey_q    <= '0;
         xs_q    <= '0;
         ys_q    <= '0;
         err_q   <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ex_q    <= ex_d;
         ey_q    <= ey_d;
         xs_q    <= xs_d;
         ys_q    <= ys_d;
         err_q   <= err_d;
         run_q   <= 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (wr_entry),
      .pop   (fifo_pop),
      .rdata (rd_entry),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_load = !out_tvalid_q || out_tready;
   assign fifo_pop = out_load && !fifo_empty;

   // Output stage holds the beat steady under backpressure and refills from the FIFO otherwise.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_tvalid_q <= 1'b0;
         out_tdata_q  <= 24'h000000;
         out_tuser_q  <= 1'b0;
         out_tlast_q  <= 1'b0;
         out_eof_q    <= 1'b0;
      end else if (out_load) begin
         if (!fifo_empty) begin
            out_tvalid_q <= 1'b1;
            out_tdata_q  <= rgb555_to_888(rd_entry.rgb);
            out_tuser_q  <= rd_entry.tuser;
            out_tlast_q  <= rd_entry.tlast;
            out_eof_q    <= rd_entry.eof;
         end else begin
            out_tvalid_q <= 1'b0;
            out_tdata_q  <= 24'h000000;
            out_tuser_q  <= 1'b0;
            out_tlast_q  <= 1'b0;
            out_eof_q    <= 1'b0;
         end
      end
   end

   assign out_tvalid = out_tvalid_q;
   assign out_tdata  = out_tdata_q;
   assign out_tuser  = out_tuser_q;
   assign out_tlast  = out_tlast_q;
   assign err_seq    = err_q;
   // Pulse must coincide with the handshake itself, so it follows out_tready directly.
   assign frame_done = out_tvalid_q && out_tready && out_eof_q;

endmodule
